rev_alu_seq: RTL and testbench



---
 rtl/rev_alu_pkg.sv | 29 ++
 rtl/rev_ripple_adder.sv | 30 +++
 rtl/rev_alu_seq.sv | 168 ++++++++++++++++
 tb/tb_rev_alu_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rev_alu_pkg.sv
// Shared types and reversible-gate primitives for the reversible-gate ALU stage.
// Garbage outputs of each primitive are dropped by returning only the target lines.
package rev_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_MUL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    // 4x4 Toffoli (CCCNOT): target y4 = x4 ^ (x1 & x2 & x3); controls pass through unused.
    function automatic logic toffoli4_y4(input logic x1, input logic x2,
                                         input logic x3, input logic x4);
        return x4 ^ (x1 & x2 & x3);
    endfunction

    // Peres gate returning {q, r} = {a ^ b, c ^ (a & b)}; the p = a line is garbage.
    function automatic logic [1:0] peres_qr(input logic pa, input logic pb, input logic pc);
        return {pa ^ pb, pc ^ (pa & pb)};
    endfunction

endpackage

// File: rtl/rev_ripple_adder.sv
// Combinational N-bit ripple adder; each full-adder cell is two cascaded Peres gates
// with the first gate's ancilla tied to 0.
module rev_ripple_adder
    import rev_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        logic [1:0] half_s;
        logic [1:0] full_s;
        // First Peres gives {a^b, a&b}; second folds in the carry to give {sum, carry}.
        assign half_s         = peres_qr(a[i], b[i], 1'b0);
        assign full_s         = peres_qr(half_s[1], carry_s[i], half_s[0]);
        assign sum[i]         = full_s[1];
        assign carry_s[i+1]   = full_s[0];
    end

    assign cout = carry_s[N];

endmodule

// File: rtl/rev_alu_seq.sv
// Sequential operand/result stage: single-cycle AND/XOR/ADD, WIDTH-step shift-add MUL,
// registered result offered over a valid/ready handshake.
module rev_alu_seq
    import rev_alu_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int RW = 2 * WIDTH;

    state_t            state_r;
    state_t            state_nxt_s;
    op_t               op_s;
    logic [RW-1:0]     result_r;
    logic [RW-1:0]     acc_r;
    logic [RW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_s;
    logic              last_step_s;
    logic [WIDTH-1:0]  and_s;
    logic [WIDTH-1:0]  xor_s;
    logic [RW-1:0]     add_a_s;
    logic [RW-1:0]     add_b_s;
    logic [RW-1:0]     sum_s;
    logic              add_cout_unused_s;

    assign op_s        = op_t'(op);
    assign accept_s    = in_valid && (state_r == IDLE);
    assign last_step_s = (state_r == EXEC) && (cnt_r == CNT_W'(WIDTH - 1));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bitwise
        // AND: Toffoli with third control tied 1, target ancilla 0.
        assign and_s[i] = toffoli4_y4(a[i], b[i], 1'b1, 1'b0);
        // XOR: Toffoli reduced to a Feynman gate by tying two controls to 1.
        assign xor_s[i] = toffoli4_y4(b[i], 1'b1, 1'b1, a[i]);
    end

    // Operand mux for the shared adder: operands in IDLE, accumulate step in EXEC.
    always_comb begin
        add_a_s = '0;
        add_b_s = '0;
        if (state_r == EXEC) begin
            add_a_s = acc_r;
            if (mplier_r[0]) begin
                add_b_s = mcand_r;
            end else begin
                add_b_s = '0;
            end
        end else begin
            add_a_s = {{WIDTH{1'b0}}, a};
            add_b_s = {{WIDTH{1'b0}}, b};
        end
    end

    rev_ripple_adder #(
        .N (RW)
    ) u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .sum  (sum_s),
        .cout (add_cout_unused_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (op_s == OP_MUL) ? EXEC : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: capture single-cycle results, load and step the shift-add multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        case (op_s)
                            OP_AND: result_r <= {{WIDTH{1'b0}}, and_s};
                            OP_XOR: result_r <= {{WIDTH{1'b0}}, xor_s};
                            OP_ADD: result_r <= sum_s;
                            OP_MUL: begin
                                mcand_r  <= {{WIDTH{1'b0}}, a};
                                mplier_r <= b;
                                acc_r    <= '0;
                                cnt_r    <= '0;
                            end
                            default: result_r <= result_r;
                        endcase
                    end
                end
                EXEC: begin
                    acc_r    <= sum_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    // The final step's sum is the full product.
                    if (last_step_s) begin
                        result_r <= sum_s;
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign result    = result_r;

endmodule

// File: tb/tb_rev_alu_seq.sv
// Self-checking bench for rev_alu_seq: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_rev_alu_seq;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    op        = 2'b00;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [RW-1:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rev_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        int xi = int'(x);
        int yi = int'(y);
        case (o)
            2'b00:   return RW'(xi & yi);
            2'b01:   return RW'(xi ^ yi);
            2'b10:   return RW'(xi + yi);
            default: return RW'(xi * yi);
        endcase
    endfunction

    // Reference model: an operation occupies the stage from acceptance until its result
    // is taken; MUL results appear W edges after acceptance, others immediately.
    logic          m_busy = 1'b0;
    logic          m_ov   = 1'b0;
    logic [RW-1:0] m_res  = '0;
    logic [RW-1:0] m_pend = '0;
    int            m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_ov   <= 1'b0;
            m_res  <= '0;
            m_left <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                if (op == 2'b11) begin
                    m_left <= W;
                    m_pend <= ref_op(op, a, b);
                end else begin
                    m_ov  <= 1'b1;
                    m_res <= ref_op(op, a, b);
                end
            end
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov   <= 1'b0;
                m_busy <= 1'b0;
            end
        end else begin
            if (m_left == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_pend;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc in_ready",  32'(in_ready),  32'(!m_busy));
            check("cyc out_valid", 32'(out_valid), 32'(m_ov));
            check("cyc busy",      32'(busy),      32'(m_busy));
            check("cyc result",    32'(result),    32'(m_res));
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [RW-1:0] exp, input int lat,
                          input int hold);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"},   32'(out_valid), 32'd1);
        check({name, " latency"}, 32'(n),         32'(lat));
        check({name, " result"},  32'(result),    32'(exp));
        check({name, " model"},   32'(m_res),     32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, " hold result"}, 32'(result),    32'(exp));
            check({name, " hold valid"},  32'(out_valid), 32'd1);
            check({name, " hold ready"},  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " drop valid"}, 32'(out_valid), 32'd0);
        check({name, " back idle"},  32'(in_ready),  32'd1);
        check({name, " kept"},       32'(result),    32'(exp));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst result",    32'(result),    32'd0);
        #1 rst_n = 1'b1;

        run_op("and",    2'b00, 4'hC, 4'hA, 8'h08, 0, 0);
        run_op("xor",    2'b01, 4'hC, 4'hA, 8'h06, 0, 0);
        run_op("add_co", 2'b10, 4'hF, 4'h1, 8'h10, 0, 0);
        run_op("add",    2'b10, 4'h7, 4'h8, 8'h0F, 0, 0);
        run_op("mul_ff", 2'b11, 4'hF, 4'hF, 8'hE1, W, 0);
        run_op("mul_0b", 2'b11, 4'h0, 4'hB, 8'h00, W, 0);
        run_op("mul_bp", 2'b11, 4'h3, 4'h5, 8'h0F, W, 10);

        // New operands held valid through EXEC/DONE must wait for IDLE.
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 2'b11;
        a         = 4'h2;
        b         = 4'h3;
        out_ready = 1'b0;
        @(negedge clk);
        op = 2'b10;
        a  = 4'h1;
        b  = 4'h1;
        check("ign busy",  32'(busy),     32'd1);
        check("ign ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ign mul result", 32'(result), 32'h06);
        repeat (3) begin
            @(negedge clk);
            check("ign hold result", 32'(result),   32'h06);
            check("ign hold ready",  32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ign idle ready", 32'(in_ready), 32'd1);
        check("ign prev kept",  32'(result),   32'h06);
        @(negedge clk);
        in_valid = 1'b0;
        check("ign next valid",  32'(out_valid), 32'd1);
        check("ign next result", 32'(result),    32'h02);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a MUL after two steps.
        in_valid = 1'b1;
        op       = 2'b11;
        a        = 4'hF;
        b        = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid rst in_ready",  32'(in_ready),  32'd1);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst busy",      32'(busy),      32'd0);
        check("mid rst result",    32'(result),    32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post rst busy",   32'(busy),   32'd0);
        check("post rst result", 32'(result), 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 2) != 0);
            op        = 2'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("drain idle", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
